// File: rtl/quad_encoder_velocity_4ch.sv
// quad_encoder_velocity_4ch
//   Four-channel 4x quadrature decoder with a fixed sample window. Each channel
//   accumulates signed ticks (saturating 16-bit). At the end of every window the
//   counts are latched and packed into offset-binary bytes (127 = stopped). The
//   packing is clamped to 0..254, so 0xFF never appears and the downstream
//   frame header stays unambiguous.
//
// Ports
//   clk_i         system clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   a_i, b_i      raw encoder phases, bit i = motor i+1, asynchronous to clk_i
//   e1_o..e4_o    per-motor window velocity, offset binary
//   valid_o       one-cycle pulse when e1_o..e4_o take a new window result
//   err_o         sticky per-channel illegal-transition flag
module quad_encoder_velocity_4ch #(
  parameter int unsigned WINDOW_CYCLES = 500000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] e1_o,
  output logic [7:0] e2_o,
  output logic [7:0] e3_o,
  output logic [7:0] e4_o,
  output logic       valid_o,
  output logic [3:0] err_o
);

  // Window timer is a down-counter: loading WinLast corresponds to window
  // position 0, and reaching zero marks the terminal cycle.
  localparam logic [23:0] WinLast      = 24'(WINDOW_CYCLES - 1);
  localparam logic [1:0]  SettleCycles = 2'd3;

  logic [3:0]        a_s1_q, b_s1_q, a_s2_q, b_s2_q, a_prev_q, b_prev_q;
  logic [1:0]        settle_q, settle_d;
  logic [23:0]       win_q, win_d;
  logic [3:0][15:0]  acc_q, acc_d;
  logic [3:0][7:0]   e_q, e_d;
  logic              valid_q, valid_d;
  logic [3:0]        err_q, err_d;
  logic              decode_en, terminal;
  logic [1:0]        pos_diff;
  logic signed [16:0] acc_sum;
  logic signed [15:0] acc_sat;

  // Position of {a,b} along the forward sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic a, input logic b);
    case ({a, b})
      2'b00:   gray_pos = 2'd0;
      2'b01:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  always_comb begin
    decode_en = (settle_q == 2'd0);
    terminal  = (win_q == 24'd0);
    win_d     = terminal ? WinLast : win_q - 24'd1;
    settle_d  = decode_en ? settle_q : settle_q - 2'd1;
    valid_d   = terminal;
    err_d     = err_q;
    acc_d     = acc_q;
    e_d       = e_q;
    pos_diff  = '0;
    acc_sum   = '0;
    acc_sat   = '0;
    for (int i = 0; i < 4; i++) begin
      // Position delta mod 4: 1 = forward, 3 = reverse, 2 = both bits flipped.
      pos_diff = gray_pos(a_s2_q[i], b_s2_q[i]) - gray_pos(a_prev_q[i], b_prev_q[i]);
      acc_sum  = {acc_q[i][15], acc_q[i]};
      if (decode_en) begin
        case (pos_diff)
          2'd1:    acc_sum = acc_sum + 17'sd1;
          2'd3:    acc_sum = acc_sum - 17'sd1;
          2'd2:    err_d[i] = 1'b1;
          default: ;
        endcase
      end
      if (acc_sum > 17'sd32767)       acc_sat = 16'sh7FFF;
      else if (acc_sum < -17'sd32768) acc_sat = 16'sh8000;
      else                            acc_sat = acc_sum[15:0];

      // The terminal-cycle step is part of the latched value, so the
      // accumulator restarts from zero rather than from that step.
      acc_d[i] = terminal ? 16'd0 : acc_sat;
      if (terminal) begin
        if (acc_sat > 16'sd127)       e_d[i] = 8'd254;
        else if (acc_sat < -16'sd127) e_d[i] = 8'd0;
        else                          e_d[i] = 8'(acc_sat + 16'sd127);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_s1_q   <= '0;
      b_s1_q   <= '0;
      a_s2_q   <= '0;
      b_s2_q   <= '0;
      a_prev_q <= '0;
      b_prev_q <= '0;
      settle_q <= SettleCycles;
      win_q    <= WinLast;
      acc_q    <= '0;
      e_q      <= {4{8'd127}};
      valid_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      a_s1_q   <= a_i;
      b_s1_q   <= b_i;
      a_s2_q   <= a_s1_q;
      b_s2_q   <= b_s1_q;
      // prev tracks s2 unconditionally, so during the settle interval it
      // absorbs the synchronizer's post-reset ramp without decoding it.
      a_prev_q <= a_s2_q;
      b_prev_q <= b_s2_q;
      settle_q <= settle_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      e_q      <= e_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign e1_o    = e_q[0];
  assign e2_o    = e_q[1];
  assign e3_o    = e_q[2];
  assign e4_o    = e_q[3];
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_quad_encoder_velocity_4ch.sv
// Directed bench for quad_encoder_velocity_4ch. The main instance uses a
// 100-cycle window; a second instance with a 500-cycle window is used for the
// negative-clamp case, which needs more than 127 steps inside one window.
module tb_quad_encoder_velocity_4ch;

  logic       clk = 1'b0;
  logic       rst_m, rst_l;
  logic [3:0] a_m, b_m, a_l, b_l;
  logic [7:0] e1_m, e2_m, e3_m, e4_m, e1_l, e2_l, e3_l, e4_l;
  logic       valid_m, valid_l;
  logic [3:0] err_m, err_l;

  int tests_run    = 0;
  int tests_failed = 0;
  int ff_hits      = 0;
  int pos_m[4];
  int pos_l[4];
  int n;

  always #5 clk = ~clk;

  quad_encoder_velocity_4ch #(.WINDOW_CYCLES(100)) u_dut (
    .clk_i(clk), .rst_i(rst_m), .a_i(a_m), .b_i(b_m),
    .e1_o(e1_m), .e2_o(e2_m), .e3_o(e3_m), .e4_o(e4_m),
    .valid_o(valid_m), .err_o(err_m)
  );

  quad_encoder_velocity_4ch #(.WINDOW_CYCLES(500)) u_dut_long (
    .clk_i(clk), .rst_i(rst_l), .a_i(a_l), .b_i(b_l),
    .e1_o(e1_l), .e2_o(e2_l), .e3_o(e3_l), .e4_o(e4_l),
    .valid_o(valid_l), .err_o(err_l)
  );

  always @(negedge clk) begin
    if (e1_m === 8'hFF || e2_m === 8'hFF || e3_m === 8'hFF || e4_m === 8'hFF ||
        e1_l === 8'hFF || e2_l === 8'hFF || e3_l === 8'hFF || e4_l === 8'hFF)
      ff_hits++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pos_ab(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic drive_step(input bit lng, input int ch, input bit fwd);
    logic [1:0] ab;
    if (lng) begin
      pos_l[ch] = (pos_l[ch] + (fwd ? 1 : 3)) % 4;
      ab = pos_ab(pos_l[ch]);
      a_l[ch] = ab[1];
      b_l[ch] = ab[0];
    end else begin
      pos_m[ch] = (pos_m[ch] + (fwd ? 1 : 3)) % 4;
      ab = pos_ab(pos_m[ch]);
      a_m[ch] = ab[1];
      b_m[ch] = ab[0];
    end
  endtask

  task automatic steps(input bit lng, input int ch, input bit fwd, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      drive_step(lng, ch, fwd);
      tick();
      tick();
    end
  endtask

  // Returns the number of edges until VALID is seen; gives up after 700.
  task automatic wait_pulse(input bit lng, output int cnt);
    logic v;
    cnt = 0;
    do begin
      tick();
      cnt++;
      v = lng ? valid_l : valid_m;
    end while (v !== 1'b1 && cnt < 700);
    check_val("valid_seen", 32'(v), 1);
  endtask

  initial begin
    rst_m = 1'b1;
    rst_l = 1'b1;
    a_m = 4'hF; b_m = 4'hF;
    a_l = 4'hF; b_l = 4'hF;
    for (int i = 0; i < 4; i++) begin
      pos_m[i] = 2;
      pos_l[i] = 2;
    end

    // Reset values with all pins high
    repeat (5) tick();
    check_val("rst_e1", e1_m, 127);
    check_val("rst_e2", e2_m, 127);
    check_val("rst_e3", e3_m, 127);
    check_val("rst_e4", e4_m, 127);
    check_val("rst_valid", valid_m, 0);
    check_val("rst_err", err_m, 0);
    rst_m = 1'b0;
    repeat (5) tick();
    check_val("err_after_settle", err_m, 0);
    wait_pulse(0, n);
    check_val("first_valid_latency", 32'(5 + n), 100);
    check_val("idle_e1", e1_m, 127);
    tick();
    check_val("valid_width", valid_m, 0);

    // Forward 40 steps on channel 1
    steps(0, 0, 1, 40);
    wait_pulse(0, n);
    check_val("fwd_e1", e1_m, 167);
    check_val("fwd_e2", e2_m, 127);
    check_val("fwd_e3", e3_m, 127);
    check_val("fwd_e4", e4_m, 127);
    wait_pulse(0, n);
    check_val("valid_period", 32'(n), 100);
    check_val("fwd_next_e1", e1_m, 127);

    // Reverse 30 steps on channel 3
    steps(0, 2, 0, 30);
    wait_pulse(0, n);
    check_val("rev_e3", e3_m, 97);

    // Reverse 200 steps on channel 3 of the long-window instance: clamps to 0
    repeat (3) tick();
    rst_l = 1'b0;
    repeat (4) tick();
    steps(1, 2, 0, 200);
    wait_pulse(1, n);
    check_val("long_valid_latency", 32'(404 + n), 500);
    check_val("sat_e3", e3_l, 0);
    check_val("sat_e1", e1_l, 127);
    check_val("sat_err", err_l, 0);

    // Illegal jump on channel 2: bring it to 00 first, then jump to 11
    wait_pulse(0, n);
    steps(0, 1, 1, 2);
    wait_pulse(0, n);
    check_val("pre_jump_e2", e2_m, 129);
    pos_m[1] = 2;
    a_m[1] = 1'b1;
    b_m[1] = 1'b1;
    tick();
    tick();
    check_val("err_before_decode", err_m, 0);
    tick();
    check_val("err_set", err_m, 4'b0010);
    wait_pulse(0, n);
    check_val("jump_e2", e2_m, 127);
    for (int w = 0; w < 3; w++) begin
      wait_pulse(0, n);
      check_val("err_sticky", err_m, 4'b0010);
    end

    // Channel 4 step decoded in the terminal cycle
    repeat (97) tick();
    drive_step(0, 3, 1);
    wait_pulse(0, n);
    check_val("term_latency", 32'(n), 3);
    check_val("term_e4", e4_m, 128);
    wait_pulse(0, n);
    check_val("term_next_e4", e4_m, 127);

    // Mid-window reset after 30 forward steps on channel 1
    steps(0, 0, 1, 30);
    rst_m = 1'b1;
    tick();
    tick();
    check_val("mid_rst_e1", e1_m, 127);
    check_val("mid_rst_valid", valid_m, 0);
    check_val("mid_rst_err", err_m, 0);
    rst_m = 1'b0;
    repeat (4) tick();
    steps(0, 0, 1, 10);
    wait_pulse(0, n);
    check_val("mid_rst_latency", 32'(24 + n), 100);
    check_val("mid_rst_post_e1", e1_m, 137);
    check_val("mid_rst_post_err", err_m, 0);

    check_val("no_ff_output", 32'(ff_hits), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
